alu_multicycle: RTL and testbench

Parametrised, registered successor to the datapath's 32-bit combinational ALU. It keeps the same operand, control and NZCV-flag interface and adds a configurable `WIDTH`. Valid/ready handshakes on input and output let it stall the pipeline. It also adds iterative multi-cycle multiply, unsigned divide and remainder, all driven by an internal state machine. It sits in the execute stage, between operand fetch and writeback.

---
 rtl/alu_multicycle.sv | 230 +++++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Registered ALU with valid/ready handshakes. Single-cycle arithmetic, logic and shift ops,
// plus iterative shift-and-add multiply and restoring unsigned divide/remainder.
module alu_multicycle #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] ALUA,
  input  logic [WIDTH-1:0] ALUB,
  input  logic [3:0]       ALUControl,
  input  logic             ALUFlagIn,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] ALUResult,
  output logic [3:0]       ALUFlags,
  output logic             Busy
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = SHW + 1;
  localparam int unsigned W1  = WIDTH + 1;

  localparam logic [3:0] OpAdd  = 4'h0;
  localparam logic [3:0] OpSub  = 4'h1;
  localparam logic [3:0] OpAnd  = 4'h2;
  localparam logic [3:0] OpOrr  = 4'h3;
  localparam logic [3:0] OpAdc  = 4'h4;
  localparam logic [3:0] OpSbc  = 4'h5;
  localparam logic [3:0] OpEor  = 4'h6;
  localparam logic [3:0] OpLsl  = 4'h7;
  localparam logic [3:0] OpLsr  = 4'h8;
  localparam logic [3:0] OpAsr  = 4'h9;
  localparam logic [3:0] OpMul  = 4'hA;
  localparam logic [3:0] OpUdiv = 4'hB;
  localparam logic [3:0] OpUrem = 4'hC;

  typedef enum logic [1:0] {StIdle, StCompute, StDone} state_e;

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  logic             accept;
  logic             multi_op;

  // Single-cycle datapath, fed straight from the input operands.
  logic [WIDTH-1:0] add_b;
  logic             add_c;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   lsl_ext, lsr_ext, asr_ext;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c, sc_v;

  // Iteration datapath.
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH:0]   div_shift, div_trial;
  logic             div_ok;
  logic [WIDTH-1:0] div_rem, div_quo;
  logic [WIDTH-1:0] fin_res;

  assign InReady  = !reset && ((state_q == StIdle) || ((state_q == StDone) && OutReady));
  assign accept   = InValid && InReady;
  assign multi_op = (ALUControl == OpMul) || (ALUControl == OpUdiv) || (ALUControl == OpUrem);

  assign OutValid  = valid_q;
  assign Busy      = busy_q;
  assign ALUResult = result_q;
  assign ALUFlags  = flags_q;

  always_comb begin
    add_b   = ((ALUControl == OpSub) || (ALUControl == OpSbc)) ? ~ALUB : ALUB;
    add_c   = (ALUControl == OpAdd) ? 1'b0 : (ALUControl == OpSub) ? 1'b1 : ALUFlagIn;
    sum     = {1'b0, ALUA} + {1'b0, add_b} + W1'(add_c);
    shamt   = ALUB[SHW-1:0];
    // One guard bit beyond the word catches the last bit shifted out.
    lsl_ext = {1'b0, ALUA} << shamt;
    lsr_ext = {ALUA, 1'b0} >> shamt;
    asr_ext = $signed({ALUA, 1'b0}) >>> shamt;

    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (ALUControl)
      OpAdd, OpSub, OpAdc, OpSbc: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (ALUA[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != ALUA[WIDTH-1]);
      end
      OpAnd: begin
        sc_res = ALUA & ALUB;
        sc_c   = ALUFlagIn;
      end
      OpOrr: begin
        sc_res = ALUA | ALUB;
        sc_c   = ALUFlagIn;
      end
      OpEor: begin
        sc_res = ALUA ^ ALUB;
        sc_c   = ALUFlagIn;
      end
      OpLsl: begin
        sc_res = lsl_ext[WIDTH-1:0];
        sc_c   = (shamt == '0) ? ALUFlagIn : lsl_ext[WIDTH];
      end
      OpLsr: begin
        sc_res = lsr_ext[WIDTH:1];
        sc_c   = (shamt == '0) ? ALUFlagIn : lsr_ext[0];
      end
      OpAsr: begin
        sc_res = asr_ext[WIDTH:1];
        sc_c   = (shamt == '0) ? ALUFlagIn : asr_ext[0];
      end
      default: begin
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
      end
    endcase
  end

  // MUL: acc += multiplicand (sa) when multiplier LSB (sb) is set.
  // DIV: acc is the partial remainder, sa the divisor, sb shifts out dividend / in quotient.
  // With a zero divisor every trial succeeds, leaving all-ones and the dividend naturally.
  always_comb begin
    mul_acc   = sb_q[0] ? (acc_q + sa_q) : acc_q;
    div_shift = {acc_q, sb_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, sa_q};
    div_ok    = !div_trial[WIDTH];
    div_rem   = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_quo   = {sb_q[WIDTH-2:0], div_ok};
    if (op_q == OpMul) begin
      fin_res = mul_acc;
    end else if (op_q == OpUdiv) begin
      fin_res = div_quo;
    end else begin
      fin_res = div_rem;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    result_d = result_q;
    flags_d  = flags_q;

    case (state_q)
      StCompute: begin
        cnt_d = cnt_q - CW'(1);
        if (op_q == OpMul) begin
          acc_d = mul_acc;
          sa_d  = sa_q << 1;
          sb_d  = sb_q >> 1;
        end else begin
          acc_d = div_rem;
          sb_d  = div_quo;
        end
        if (cnt_q == CW'(1)) begin
          state_d  = StDone;
          result_d = fin_res;
          flags_d  = {fin_res[WIDTH-1], fin_res == '0, 1'b0,
                      (op_q != OpMul) && (sa_q == '0)};
        end
      end
      StDone: begin
        if (OutReady) state_d = StIdle;
      end
      default: ;
    endcase

    // Accepting from DONE behaves exactly like accepting from IDLE.
    if (accept) begin
      op_d = ALUControl;
      if (multi_op) begin
        state_d = StCompute;
        cnt_d   = CW'(WIDTH);
        acc_d   = '0;
        sa_d    = (ALUControl == OpMul) ? ALUA : ALUB;
        sb_d    = (ALUControl == OpMul) ? ALUB : ALUA;
      end else begin
        state_d  = StDone;
        result_d = sc_res;
        flags_d  = {sc_res[WIDTH-1], sc_res == '0, sc_c, sc_v};
      end
    end

    valid_d = (state_d == StDone);
    busy_d  = (state_d == StCompute);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      sa_q     <= '0;
      sb_q     <= '0;
      result_q <= '0;
      flags_q  <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle (WIDTH = 32) with hand-computed expected values.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        reset;
  logic        InValid;
  logic        InReady;
  logic [31:0] ALUA, ALUB;
  logic [3:0]  ALUControl;
  logic        ALUFlagIn;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] ALUResult;
  logic [3:0]  ALUFlags;
  logic        Busy;

  int vectors = 0;
  int miscompares = 0;
  int last_busy;
  int last_ir_high_busy;

  alu_multicycle #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .InValid   (InValid),
    .InReady   (InReady),
    .ALUA      (ALUA),
    .ALUB      (ALUB),
    .ALUControl(ALUControl),
    .ALUFlagIn (ALUFlagIn),
    .OutValid  (OutValid),
    .OutReady  (OutReady),
    .ALUResult (ALUResult),
    .ALUFlags  (ALUFlags),
    .Busy      (Busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op with OutReady high, then check latency, result and flags.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic [31:0] er, input logic [3:0] ef,
                        input int lat, input string tag);
    int n;
    OutReady   = 1'b1;
    ALUControl = op;
    ALUA       = a;
    ALUB       = b;
    ALUFlagIn  = cin;
    InValid    = 1'b1;
    check({tag, "_inready"}, {31'd0, InReady}, 32'd1);
    tick();
    InValid   = 1'b0;
    ALUA      = ~a;
    ALUB      = ~b;
    ALUFlagIn = ~cin;
    ALUControl = 4'h0;
    n = 1;
    last_busy = 0;
    last_ir_high_busy = 0;
    while (!OutValid && n < 100) begin
      if (Busy) last_busy++;
      if (Busy && InReady) last_ir_high_busy++;
      tick();
      n++;
    end
    check({tag, "_lat"}, n, lat);
    check({tag, "_res"}, ALUResult, er);
    check({tag, "_flags"}, {28'd0, ALUFlags}, {28'd0, ef});
  endtask

  initial begin
    reset      = 1'b1;
    InValid    = 1'b0;
    OutReady   = 1'b0;
    ALUA       = '0;
    ALUB       = '0;
    ALUControl = '0;
    ALUFlagIn  = 1'b0;
    tick();
    tick();
    check("rst_inready", {31'd0, InReady}, 32'd0);
    check("rst_outvalid", {31'd0, OutValid}, 32'd0);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_result", ALUResult, 32'd0);
    check("rst_flags", {28'd0, ALUFlags}, 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_inready", {31'd0, InReady}, 32'd1);
    tick();

    run_op(4'h0, 32'd15, 32'd1, 1'b1, 32'd16, 4'b0000, 1, "add");
    run_op(4'h0, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 4'b1001, 1, "add_ovf");
    run_op(4'h1, 32'd120, 32'd32, 1'b0, 32'd88, 4'b0010, 1, "sub");
    run_op(4'h5, 32'd192, 32'd69, 1'b0, 32'd122, 4'b0010, 1, "sbc");
    run_op(4'h8, 32'h8000_0001, 32'd1, 1'b0, 32'h4000_0000, 4'b0010, 1, "lsr");
    run_op(4'h9, 32'h8000_0000, 32'd4, 1'b0, 32'hF800_0000, 4'b1000, 1, "asr");
    run_op(4'h7, 32'h1234_5678, 32'h0000_0100, 1'b1, 32'h1234_5678, 4'b0010, 1, "lsl0");
    run_op(4'hE, 32'd7, 32'd9, 1'b1, 32'd0, 4'b0100, 1, "reserved");

    run_op(4'hA, 32'd123412, 32'd64, 1'b0, 32'd7898368, 4'b0000, 33, "mul");
    check("mul_busy_cycles", last_busy, 32'd32);
    check("mul_inready_low", last_ir_high_busy, 32'd0);
    run_op(4'hB, 32'd123412, 32'd64, 1'b0, 32'd1928, 4'b0000, 33, "udiv");
    run_op(4'hC, 32'd123412, 32'd64, 1'b0, 32'd20, 4'b0000, 33, "urem");
    run_op(4'hB, 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 4'b1001, 33, "udiv0");
    run_op(4'hC, 32'd5, 32'd0, 1'b0, 32'd5, 4'b0001, 33, "urem0");
    run_op(4'hB, 32'd3, 32'd10, 1'b0, 32'd0, 4'b0100, 33, "udiv_small");

    // Backpressure: hold the AND result while a new op waits.
    tick();
    OutReady   = 1'b0;
    ALUControl = 4'h2;
    ALUA       = 32'h0000_F0F0;
    ALUB       = 32'h0000_FF00;
    ALUFlagIn  = 1'b0;
    InValid    = 1'b1;
    tick();
    ALUControl = 4'h0;
    ALUA       = 32'd100;
    ALUB       = 32'd1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'd0, OutValid}, 32'd1);
      check("bp_result", ALUResult, 32'h0000_F000);
      check("bp_flags", {28'd0, ALUFlags}, 32'd0);
      check("bp_inready", {31'd0, InReady}, 32'd0);
      tick();
    end
    OutReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ALUA = 32'd10 * i;
      ALUB = i + 1;
      tick();
      check("stream_valid", {31'd0, OutValid}, 32'd1);
      check("stream_res", ALUResult, 32'd11 * i + 1);
    end
    InValid = 1'b0;
    tick();
    check("stream_drained", {31'd0, OutValid}, 32'd0);

    // Reset in the middle of a multiply.
    ALUControl = 4'hA;
    ALUA       = 32'd123412;
    ALUB       = 32'd64;
    InValid    = 1'b1;
    tick();
    InValid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("mid_busy_before", {31'd0, Busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, Busy}, 32'd0);
    check("mid_rst_valid", {31'd0, OutValid}, 32'd0);
    check("mid_rst_inready", {31'd0, InReady}, 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (OutValid) check("mid_no_result", {31'd0, OutValid}, 32'd0);
      tick();
    end
    check("mid_idle_valid", {31'd0, OutValid}, 32'd0);
    run_op(4'h0, 32'd2, 32'd3, 1'b0, 32'd5, 4'b0000, 1, "add_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
